solution_streamer: RTL and testbench

SOLUTION_STREAMER -- requirements
Module: solution_streamer

---
 rtl/nonogram_pkg.sv | 19 +
 rtl/row_byte_mux.sv | 37 +++
 rtl/solution_streamer.sv | 100 ++++++++++
 tb/tb_solution_streamer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/nonogram_pkg.sv
// Shared types and helpers for the nonogram solution streamer.
package nonogram_pkg;

  localparam int MAX_DIM_DEF = 11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT,
    FINISH
  } state_t;

  // Byte counter width: header (2) + two bytes per row + optional checksum.
  function automatic int cnt_width(input int max_dim);
    return $clog2(2 * max_dim + 3);
  endfunction

endpackage

// File: rtl/row_byte_mux.sv
// Combinational byte selector: header bytes n/m, then low/high half of each
// row with columns at index >= m forced to zero.
module row_byte_mux
  import nonogram_pkg::*;
#(
  parameter int MAX_DIM = MAX_DIM_DEF,
  parameter int IDX_W   = cnt_width(MAX_DIM)
) (
  input  logic [MAX_DIM*MAX_DIM-1:0] grid,
  input  logic [3:0]                 n,
  input  logic [3:0]                 m,
  input  logic [IDX_W-1:0]           idx,
  output logic [7:0]                 byte_sel
);

  logic [IDX_W-1:0]   row_idx;
  logic [MAX_DIM-1:0] row;
  logic [MAX_DIM-1:0] mask;
  logic [15:0]        row_pad;

  // Pick the row addressed by idx, mask unused columns, split into halves.
  always_comb begin
    row_idx = (idx - IDX_W'(2)) >> 1;
    row     = '0;
    for (int r = 0; r < MAX_DIM; r++)
      if (row_idx == IDX_W'(r)) row = grid[r*MAX_DIM +: MAX_DIM];
    mask = '0;
    for (int c = 0; c < MAX_DIM; c++)
      mask[c] = (4'(c) < m);
    row_pad = 16'(row & mask);
    if (idx == IDX_W'(0))      byte_sel = {4'b0, n};
    else if (idx == IDX_W'(1)) byte_sel = {4'b0, m};
    else if (idx[0])           byte_sel = row_pad[15:8];
    else                       byte_sel = row_pad[7:0];
  end

endmodule

// File: rtl/solution_streamer.sv
// Streams a solved nonogram grid to a UART transmitter, one byte per
// tx_done handshake: n, m, then low/high bytes per row.
// Optional: define STREAMER_CHECKSUM_EN to append an XOR checksum byte.
module solution_streamer
  import nonogram_pkg::*;
#(
  parameter int MAX_DIM = MAX_DIM_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [MAX_DIM*MAX_DIM-1:0] solution,
  input  logic [3:0]                 n,
  input  logic [3:0]                 m,
  input  logic                       tx_done,
  output logic                       valid_out,
  output logic [7:0]                 byte_out,
  output logic                       busy,
  output logic                       done
);

  localparam int         IDX_W = cnt_width(MAX_DIM);
  localparam logic [3:0] DIM4  = 4'(MAX_DIM);

  state_t                     state, state_nx;
  logic [MAX_DIM*MAX_DIM-1:0] grid;
  logic [3:0]                 n_q, m_q;
  logic [IDX_W-1:0]           idx;       // bytes already emitted
  logic [IDX_W-1:0]           rows_end;  // index just past the last row byte
  logic [IDX_W-1:0]           total;
  logic [7:0]                 row_byte, cur_byte;

  assign rows_end = IDX_W'({n_q, 1'b0}) + IDX_W'(2);

  row_byte_mux #(.MAX_DIM(MAX_DIM), .IDX_W(IDX_W)) u_mux (
    .grid     (grid),
    .n        (n_q),
    .m        (m_q),
    .idx      (idx),
    .byte_sel (row_byte)
  );

`ifdef STREAMER_CHECKSUM_EN
  logic [7:0] csum;

  assign total    = rows_end + IDX_W'(1);
  assign cur_byte = (idx == rows_end) ? csum : row_byte;

  // Running XOR of every byte as it is presented to the transmitter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     csum <= '0;
    else if (state == IDLE && start) csum <= '0;
    else if (state == SEND)          csum <= csum ^ byte_out;
  end
`else
  assign total    = rows_end;
  assign cur_byte = row_byte;
`endif

  // Next-state logic; tx_done only matters while waiting on a byte.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = SEND;
      SEND:    state_nx = WAIT;
      WAIT:    if (tx_done) state_nx = (idx == total) ? FINISH : SEND;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, latched job data, byte counter and the held output byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grid     <= '0;
      n_q      <= '0;
      m_q      <= '0;
      idx      <= '0;
      byte_out <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        grid <= solution;
        n_q  <= (n > DIM4) ? DIM4 : n;
        m_q  <= (m > DIM4) ? DIM4 : m;
        idx  <= '0;
      end
      if (state == SEND) idx <= idx + IDX_W'(1);
      // byte_out changes only on entry to SEND, so it holds between bytes.
      if (state_nx == SEND) byte_out <= cur_byte;
    end
  end

  assign valid_out = (state == SEND);
  assign busy      = (state == LOAD) || (state == SEND) || (state == WAIT);
  assign done      = (state == FINISH);

endmodule

// File: tb/tb_solution_streamer.sv
// Directed bench for solution_streamer (MAX_DIM = 11).
// Honors STREAMER_CHECKSUM_EN when expecting the trailing checksum byte.
module tb_solution_streamer;

  localparam int D = 11;

  logic             clk, rst_n, start, tx_done;
  logic [D*D-1:0]   solution;
  logic [3:0]       n, m;
  logic             valid_out, busy, done;
  logic [7:0]       byte_out;

  int errors = 0;
  int checks = 0;

  logic [7:0] got [64];
  int         vcyc[64];
  int         got_n, dcount, busy_bad, stable_bad, first_lat, done_lat, extra;
  logic       busy_at_done;
  logic [7:0] exp_q[$];

  solution_streamer #(.MAX_DIM(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .solution  (solution),
    .n         (n),
    .m         (m),
    .tx_done   (tx_done),
    .valid_out (valid_out),
    .byte_out  (byte_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add_csum();
`ifdef STREAMER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    exp_q.push_back(x);
`endif
  endfunction

  // Starts one stream and plays the UART: tx_done 'gap' cycles after each
  // valid_out. Collects bytes and timing; comparisons live in the tests.
  task automatic stream(input int gap, input bit spur, input bit scramble);
    int cyc, cnt, last_tx;
    logic [7:0] last;
    got_n = 0; dcount = 0; busy_bad = 0; stable_bad = 0; extra = 0;
    first_lat = -1; done_lat = -1; cnt = 0; last_tx = 0; last = 8'h00;
    busy_at_done = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin solution = ~solution; n = 4'd7; m = 4'd2; end
    cyc = 1;
    while (dcount == 0 && cyc < 400) begin
      tx_done = 1'b0; start = 1'b0;
      if (done) begin
        dcount++; done_lat = cyc - last_tx; busy_at_done = busy;
        if (got_n > 0 && byte_out !== last) stable_bad++;
      end else if (valid_out) begin
        if (got_n < 64) begin got[got_n] = byte_out; vcyc[got_n] = cyc; end
        got_n++;
        if (first_lat < 0) first_lat = cyc;
        last = byte_out; cnt = gap;
        if (!busy) busy_bad++;
        if (spur) begin start = 1'b1; tx_done = 1'b1; end
      end else begin
        if (!busy) busy_bad++;
        if (got_n > 0 && byte_out !== last) stable_bad++;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin tx_done = 1'b1; last_tx = cyc; end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    tx_done = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (valid_out || done) extra++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; tx_done = 1'b0;
    solution = '0; n = '0; m = '0;
    #3;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
    checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", byte_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    solution = '0; solution[0 +: D] = 11'b101; solution[D +: D] = 11'b011;
    n = 4'd2; m = 4'd3;
    exp_q = '{8'h02, 8'h03, 8'h05, 8'h00, 8'h03, 8'h00}; add_csum();
    stream(5, 1'b0, 1'b1);
    checks++; if (got_n !== exp_q.size()) begin errors++; $display("FAIL basic_count got %0d want %0d", got_n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (first_lat !== 2) begin errors++; $display("FAIL basic_first_latency got %0d want 2", first_lat); end
    checks++; if (vcyc[1] - vcyc[0] !== 6) begin errors++; $display("FAIL basic_gap got %0d want 6", vcyc[1] - vcyc[0]); end
    checks++; if (dcount !== 1 || extra !== 0) begin errors++; $display("FAIL basic_done got %0d extra %0d want 1 extra 0", dcount, extra); end
    checks++; if (done_lat !== 1) begin errors++; $display("FAIL basic_done_latency got %0d want 1", done_lat); end
    checks++; if (busy_bad !== 0 || busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy low %0d at_done %b want 0 0", busy_bad, busy_at_done); end
    checks++; if (stable_bad !== 0) begin errors++; $display("FAIL basic_hold got %0d changes want 0", stable_bad); end
  endtask

  task automatic test_full;
    solution = '1; n = 4'd11; m = 4'd11;
    exp_q = '{8'h0B, 8'h0B};
    for (int r = 0; r < D; r++) begin exp_q.push_back(8'hFF); exp_q.push_back(8'h07); end
    add_csum();
    stream(2, 1'b0, 1'b0);
    checks++; if (got_n !== exp_q.size()) begin errors++; $display("FAIL full_count got %0d want %0d", got_n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL full_byte%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (dcount !== 1) begin errors++; $display("FAIL full_done got %0d want 1", dcount); end
  endtask

  task automatic test_saturate;
    solution = '1; n = 4'd13; m = 4'd14;
    exp_q = '{8'h0B, 8'h0B};
    for (int r = 0; r < D; r++) begin exp_q.push_back(8'hFF); exp_q.push_back(8'h07); end
    add_csum();
    stream(1, 1'b0, 1'b0);
    checks++; if (got_n !== exp_q.size()) begin errors++; $display("FAIL sat_count got %0d want %0d", got_n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL sat_byte%0d got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_mask;
    solution = '1; n = 4'd1; m = 4'd4;
    exp_q = '{8'h01, 8'h04, 8'h0F, 8'h00}; add_csum();
    stream(3, 1'b0, 1'b0);
    checks++; if (got_n !== exp_q.size()) begin errors++; $display("FAIL mask_count got %0d want %0d", got_n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL mask_byte%0d got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_spurious;
    solution = '0; solution[0 +: D] = 11'b101; solution[D +: D] = 11'b011;
    n = 4'd2; m = 4'd3;
    exp_q = '{8'h02, 8'h03, 8'h05, 8'h00, 8'h03, 8'h00}; add_csum();
    stream(4, 1'b1, 1'b0);
    checks++; if (got_n !== exp_q.size()) begin errors++; $display("FAIL spur_count got %0d want %0d", got_n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL spur_byte%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (vcyc[1] - vcyc[0] !== 5) begin errors++; $display("FAIL spur_gap got %0d want 5", vcyc[1] - vcyc[0]); end
    checks++; if (dcount !== 1 || extra !== 0) begin errors++; $display("FAIL spur_done got %0d extra %0d want 1 extra 0", dcount, extra); end
  endtask

  task automatic test_reset_mid;
    int vc, cyc, cnt, stray;
    solution = '0; solution[0 +: D] = 11'b101; solution[D +: D] = 11'b011;
    n = 4'd2; m = 4'd3;
    vc = 0; cyc = 0; cnt = 0; stray = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (vc < 3 && cyc < 100) begin
      tx_done = 1'b0;
      if (valid_out) begin vc++; cnt = 2; end
      else if (cnt > 0) begin cnt--; if (cnt == 0) tx_done = 1'b1; end
      if (vc < 3) begin @(posedge clk); #1; cyc++; end
    end
    tx_done = 1'b0;
    checks++; if (vc !== 3) begin errors++; $display("FAIL rstmid_reach got %0d bytes want 3", vc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({valid_out, busy, done} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got %b want 000", {valid_out, busy, done}); end
    checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL rstmid_byte got %h want 00", byte_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (valid_out || busy || byte_out !== 8'h00) stray++;
      @(posedge clk); #1;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rstmid_idle got %0d active cycles want 0", stray); end
    exp_q = '{8'h02, 8'h03, 8'h05, 8'h00, 8'h03, 8'h00}; add_csum();
    stream(2, 1'b0, 1'b0);
    checks++; if (got_n !== exp_q.size()) begin errors++; $display("FAIL rstmid_count got %0d want %0d", got_n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_byte%0d got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_zero_rows;
    solution = '1; n = 4'd0; m = 4'd5;
    exp_q = '{8'h00, 8'h05}; add_csum();
    stream(3, 1'b0, 1'b0);
    checks++; if (got_n !== exp_q.size()) begin errors++; $display("FAIL zero_count got %0d want %0d", got_n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL zero_byte%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (dcount !== 1 || done_lat !== 1) begin errors++; $display("FAIL zero_done got %0d latency %0d want 1 latency 1", dcount, done_lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_saturate();
    test_mask();
    test_spurious();
    test_reset_mid();
    test_zero_rows();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
